// File: rtl/l1_dcache_responder.sv
// rtl/l1_dcache_responder.sv - direct-mapped write-back L1 data cache answering MEM-stage requests
// Single-cycle hits in IDLE; misses walk WRITEBACK (if dirty) then FILL.
module l1_dcache_responder #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TW-1:0]       tag_arr  [NUM_SETS];
  logic [127:0]        data_arr [NUM_SETS];

  logic          req;
  logic          hit;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [2:0]    req_word;
  logic [15:0]   merged_word;

  // Miss address is captured so the refill completes even if the initiator withdraws.
  logic [15:0]   miss_addr;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;

  assign req      = mem_read | mem_write;
  assign req_idx  = mem_address[3+IW:4];
  assign req_tag  = mem_address[15:4+IW];
  assign req_word = mem_address[3:1];
  assign miss_idx = miss_addr[3+IW:4];
  assign miss_tag = miss_addr[15:4+IW];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  assign mem_rdata   = data_arr[req_idx][{req_word, 4'b0000} +: 16];
  assign pmem_wdata  = data_arr[miss_idx];
  assign merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : mem_rdata[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : mem_rdata[7:0]};

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {miss_tag, miss_idx, 4'b0000};
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
          end else if (dirty[req_idx]) begin
            state_next = WRITEBACK;
          end else begin
            state_next = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
        if (pmem_resp) begin
          state_next = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (mem_resp && mem_write) begin
            dirty[req_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[miss_idx] <= 1'b0;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag/data storage is deliberately not reset; valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && !hit) begin
      miss_addr <= mem_address;
    end
    if (rst_n) begin
      if (state == FILL && pmem_resp) begin
        data_arr[miss_idx] <= pmem_rdata;
        tag_arr[miss_idx]  <= miss_tag;
      end else if (mem_resp && mem_write) begin
        data_arr[req_idx][{req_word, 4'b0000} +: 16] <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache_responder.sv
// tb/tb_l1_dcache_responder.sv - directed vector bench for l1_dcache_responder with a pmem model
module tb_l1_dcache_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address, mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  l1_dcache_responder #(.NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int presp_cyc = 0;
  int overlap = 0;
  int pcnt = 0;
  localparam int PDELAY = 5;

  logic         saw_wb, saw_fill;
  logic [15:0]  wb_addr, fill_addr;
  logic [127:0] wb_data;
  logic [127:0] bmem [logic [15:0]];

  function automatic logic [127:0] default_line(input logic [15:0] la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = la + 16'(2 * w);
    return l;
  endfunction

  function automatic logic [127:0] fetch(input logic [15:0] la);
    if (bmem.exists(la)) return bmem[la];
    return default_line(la);
  endfunction

  always @(posedge clk) cyc_cnt++;

  // Backing memory: answers each pmem request PDELAY+1 negedges after it appears.
  always @(negedge clk) begin
    if (pmem_read && pmem_write) overlap++;
    if (pmem_write) begin saw_wb = 1'b1; wb_addr = pmem_address; wb_data = pmem_wdata; end
    if (pmem_read) begin saw_fill = 1'b1; fill_addr = pmem_address; end
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      pcnt = 0;
    end else if (pmem_read || pmem_write) begin
      if (pcnt == PDELAY) begin
        if (pmem_write) bmem[pmem_address] = pmem_wdata;
        else pmem_rdata = fetch(pmem_address);
        pmem_resp = 1'b1;
        presp_cyc = cyc_cnt;
        pcnt = 0;
      end else begin
        pcnt++;
      end
    end else begin
      pcnt = 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         output logic got, output logic [15:0] data, output int lat,
                         output int rcyc);
    int start;
    saw_wb = 1'b0;
    saw_fill = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    start = cyc_cnt;
    got = 1'b0; data = '0; lat = 0; rcyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (mem_resp) begin
        got = 1'b1; data = mem_rdata; lat = cyc_cnt - start; rcyc = cyc_cnt;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_wb;
    logic        exp_fill;
    logic [15:0] exp_wb_addr;
    logic [15:0] exp_victim;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic         got;
    logic [15:0]  data;
    logic [127:0] l;
    logic [127:0] wdat;
    int           lat, rcyc;
    bit           seen;

    vecs[0]  = '{1'b1, 1'b0, 16'h1232, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h1232, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h1232, 16'h5500, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h1232, 16'h0000, 2'b00, 16'h55EF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h2232, 16'h0000, 2'b00, 16'h2232, 1'b1, 1'b1, 16'h1230, 16'h55EF};
    vecs[5]  = '{1'b1, 1'b0, 16'h1232, 16'h0000, 2'b00, 16'h55EF, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'h1234, 16'hA5A5, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h2234, 16'h0000, 2'b00, 16'h2234, 1'b1, 1'b1, 16'h1230, 16'h1234};
    vecs[9]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b00, 16'hFFFE, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 16'hFFFE, 16'h0077, 2'b01, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b00, 16'hFF77, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 1'b1, 16'h0450, 16'h1111, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 16'h0450, 16'h0000, 2'b00, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[14] = '{1'b1, 1'b0, 16'h0C50, 16'h0000, 2'b00, 16'h0C50, 1'b1, 1'b1, 16'h0450, 16'h1111};

    l = default_line(16'h1230);
    l[31:16] = 16'hBEEF;
    bmem[16'h1230] = l;

    pmem_resp = 1'b0; pmem_rdata = '0;
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h1232;
    mem_wdata = '0; mem_byte_enable = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_mem_resp", mem_resp, 1'b0);
    check("reset_pmem_read", pmem_read, 1'b0);
    check("reset_pmem_write", pmem_write, 1'b0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, got, data, lat, rcyc);
      check($sformatf("v%0d_resp", i), got, 1'b1);
      check($sformatf("v%0d_writeback", i), saw_wb, vecs[i].exp_wb);
      check($sformatf("v%0d_fill", i), saw_fill, vecs[i].exp_fill);
      if (vecs[i].rd && !vecs[i].wr) check($sformatf("v%0d_rdata", i), data, vecs[i].exp_rdata);
      if (vecs[i].exp_wb) begin
        wdat = wb_data;
        check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("v%0d_victim_word", i), wdat[{vecs[i].addr[3:1], 4'b0000} +: 16], vecs[i].exp_victim);
      end
      if (vecs[i].exp_fill) begin
        check($sformatf("v%0d_fill_addr", i), fill_addr, vecs[i].addr & 16'hFFF0);
        check($sformatf("v%0d_resp_after_pmem_resp", i), rcyc, presp_cyc + 1);
      end else begin
        check($sformatf("v%0d_hit_latency", i), lat, 0);
      end
    end

    // Reset while a fill is outstanding.
    saw_fill = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h3332;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (pmem_read) seen = 1'b1;
    end
    check("rst_fill_started", seen, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_pmem_read_dropped", pmem_read, 1'b0);
    check("rst_no_mem_resp", mem_resp, 1'b0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    run_req(1'b1, 1'b0, 16'h3332, 16'h0, 2'b00, got, data, lat, rcyc);
    check("post_rst_refill", saw_fill, 1'b1);
    check("post_rst_rdata", data, 16'h3332);
    run_req(1'b1, 1'b0, 16'hFFFE, 16'h0, 2'b00, got, data, lat, rcyc);
    check("post_rst_no_writeback", saw_wb, 1'b0);
    check("post_rst_lost_dirty_rdata", data, 16'hFFFE);

    // Request withdrawn mid-miss: line still installed, no response produced.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h5552;
    @(negedge clk); @(negedge clk);
    mem_read = 1'b0; mem_address = 16'h0000;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (mem_resp) seen = 1'b1;
    end
    check("withdrawn_no_resp", seen, 1'b0);
    check("withdrawn_fill_done", pmem_read, 1'b0);
    run_req(1'b1, 1'b0, 16'h5552, 16'h0, 2'b00, got, data, lat, rcyc);
    check("withdrawn_then_hit_latency", lat, 0);
    check("withdrawn_then_hit_nofill", saw_fill, 1'b0);
    check("withdrawn_then_hit_rdata", data, 16'h5552);

    check("pmem_rw_exclusive", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_dcache_responder.md
Name: l1_dcache_responder

Overview:
- Responder end of the pipeline data-memory interface: services the MEM stage's word/byte read and write requests and returns mem_resp/mem_rdata.
- Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the physical memory (pmem) port.
- 16-byte lines; fills and evictions use a 128-bit line handshake to pmem.
- The initiator holds its request stable until mem_resp and stalls its pipeline register on it.

Parameters:
NUM_SETS, 8, number of lines (power of 2, >=2); index width IW = log2(NUM_SETS), tag width = 12 - IW

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
mem_read  input  1  read request from MEM stage
mem_write  input  1  write request from MEM stage
mem_address  input  16  byte address; [3:1] word select, [3+IW:4] index, [15:4+IW] tag
mem_wdata  input  16  write data, byte lanes already positioned by initiator
mem_byte_enable  input  2  write mask: [0]=low byte, [1]=high byte
mem_rdata  output  16  read word selected by mem_address[3:1]
mem_resp  output  1  one-cycle completion pulse
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_address  output  16  line address, [3:0]=0
pmem_wdata  output  128  victim line data
pmem_rdata  input  128  fill line data
pmem_resp  input  1  pmem completion, one-cycle pulse

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (rst_n).
- On reset: all valid and dirty bits = 0, state = IDLE, and mem_resp, pmem_read, pmem_write = 0.
  - Tag and data arrays are not cleared.
  - mem_rdata and pmem_address/pmem_wdata are don't-care until used.
- Storage per set: valid, dirty, tag, and 128-bit data.
- Request: req = mem_read | mem_write. Both asserted is treated as a write.
- hit = valid[idx] & (tag[idx] == addr tag).
- States:
  - IDLE: no req -> stay, no outputs.
    - req & hit -> mem_resp = 1 in the same cycle (combinational; single-cycle hit).
    - Read hit: mem_rdata = line word [addr[3:1]] in that cycle.
    - Write hit: at the clock edge, bytes with byte_enable set are merged into the word and dirty[idx] = 1.
    - req & miss & dirty[idx] -> WRITEBACK. req & miss & !dirty -> FILL.
  - WRITEBACK:
    - pmem_write = 1; pmem_address = {stored tag, idx, 4'b0}; pmem_wdata = stored line.
    - Held until pmem_resp; on pmem_resp -> FILL, with dirty[idx] cleared.
  - FILL:
    - pmem_read = 1; pmem_address = {req tag, idx, 4'b0}.
    - On pmem_resp: line = pmem_rdata, tag written, valid = 1, dirty = 0 -> IDLE.
    - The request then hits on the next cycle.
- mem_resp is never asserted outside IDLE.
- Miss latency = writeback time (if dirty) + fill time + 1 cycle (the hit).
- pmem_read and pmem_write are never asserted together. Each is deasserted in the cycle after pmem_resp.
- Request deassertion mid-miss: the fill/writeback still completes and the line is installed; no mem_resp is generated.
- Reset during WRITEBACK or FILL: the transaction is abandoned and pmem requests drop on the next cycle.
  - All lines become invalid, so no partially filled line can hit.
- Write hit with mem_byte_enable = 2'b00: mem_resp = 1, data unchanged, dirty still set.
- Index/tag extraction wraps naturally. Address 0xFFFE maps to set NUM_SETS-1, word 7.

Test Plan:
- Cold read:
  - Stimulus: reset, then mem_read @0x1232; pmem returns line with word1 = 0xBEEF after 5 cycles.
  - Required: pmem_read with pmem_address = 0x1230; no pmem_write; then mem_resp with mem_rdata = 0xBEEF one cycle after pmem_resp.
- Read hit:
  - Stimulus: a second mem_read @0x1232.
  - Required: mem_resp in the same cycle as the request, mem_rdata = 0xBEEF, pmem_read = 0 throughout.
- Byte write hit:
  - Stimulus: mem_write @0x1232, wdata = 0x5500, byte_enable = 2'b10; then read @0x1232.
  - Required: the write gets a 1-cycle mem_resp; the read returns 0x55EF.
- Dirty eviction (NUM_SETS = 8):
  - Stimulus: write @0x1232 as above, then read @0x2232 (same set, different tag).
  - Required: pmem_write with pmem_address = 0x1230 and pmem_wdata word1 = 0x55EF; then pmem_read @0x2230; then mem_resp.
  - Re-reading 0x1232 must miss again.
- Reset mid-fill:
  - Stimulus: assert rst_n = 0 while pmem_read = 1.
  - Required: pmem_read = 0 the next cycle; after release, a read of the same address misses and refills.
- Clean miss with both mem_read and mem_write high:
  - Required: no pmem_write; the request is handled as a write, and the line is dirty afterwards.
  - Check: a later conflicting miss produces a writeback.
